mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit address/data, 4-bit masks).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_addr  input  32  instruction fetch address from core.
REQ-005 imem_rmask  input  4  nonzero = fetch request pending; held until imem_resp.
REQ-006 imem_rdata  output  32  fetched word, valid when imem_resp=1.
REQ-007 imem_resp  output  1  one-cycle fetch completion pulse.
REQ-008 dmem_addr, dmem_wdata  input  32 each  data-side address/store data.
REQ-009 dmem_rmask, dmem_wmask  input  4 each  either nonzero = data request pending; held until dmem_resp.
REQ-010 dmem_rdata  output  32; dmem_resp  output  1  load data / one-cycle completion pulse.
REQ-011 mem_addr, mem_wdata  output  32; mem_rmask, mem_wmask  output  4  unified memory request, held until mem_resp.
REQ-012 mem_rdata  input  32; mem_resp  input  1  unified memory completion, any latency >=1 cycle.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-014 IDLE: dmem pending -> latch dmem addr/masks/wdata, go BUSY_D; else imem pending -> latch imem addr/rmask (wmask=0, wdata=0), go BUSY_I; else stay.
REQ-015 mem_* outputs SHALL be registered: driven with latched request from the cycle after grant until the cycle mem_resp=1 inclusive; all-zero masks otherwise.
REQ-016 BUSY_x: on mem_resp=1 capture mem_rdata into x's rdata register, go RESP; else hold outputs unchanged.
REQ-017 RESP: assert the granted side's *_resp for exactly one cycle with captured rdata; then IDLE; no request sampled in RESP.
REQ-018 Latency: request visible in IDLE cycle 0 -> mem request cycle 1 -> mem_resp cycle k -> core resp cycle k+1 -> IDLE cycle k+2.
REQ-019 imem_resp and dmem_resp SHALL never be asserted in the same cycle.
REQ-020 Store (wmask nonzero): dmem_rdata after completion = mem_rdata as returned (don't-care); masks forwarded unmodified, including rmask and wmask both nonzero.
REQ-021 rdata outputs SHALL hold last captured value between responses.
REQ-022 mem_resp in IDLE or RESP SHALL be ignored.
REQ-023 Core request changes while BUSY SHALL not affect the in-flight mem request.

Reset
REQ-024 rst=1 SHALL immediately force IDLE; all mem_* outputs, *_rdata, *_resp, latched request and last-grant flop to 0.
REQ-025 Reset mid-transaction SHALL abandon it; no core resp generated for it.

Configuration
REQ-026 MEM_ARB_RR_EN defined: when both sides pending in IDLE, grant the side not granted last (last-grant resets to imem, so dmem wins first conflict); single pending side granted directly.
REQ-027 MEM_ARB_RR_EN undefined: dmem SHALL always win conflicts; no last-grant flop.

Structure
REQ-028 arb_state_t enum and mem_req_t struct (addr, rmask, wmask, wdata) SHALL live in rv32i_types.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 imem_addr=0x6000_0000, rmask=0xF, mem_resp at 3rd BUSY cycle, mem_rdata=0x0000_0013 -> mem_rmask=0xF cycles 1-3, imem_resp=1 cycle 4 with rdata 0x0000_0013, dmem_resp=0 throughout.
REQ-031 Store dmem_addr=0x6000_1004, wmask=0x3, wdata=0xDEAD_BEEF, mem_resp 1 cycle after request -> mem_wmask=0x3, mem_wdata=0xDEAD_BEEF, mem_rmask=0, dmem_resp one cycle.
REQ-032 Both pending same cycle, default build -> dmem served first, imem second; with MEM_ARB_RR_EN and continuous both-pending -> grants alternate D,I,D,I.
REQ-033 rst pulsed during BUSY_D with mem_resp arriving after reset -> all outputs 0, no dmem_resp, FSM IDLE, next imem request served normally.
REQ-034 mem_resp=1 while IDLE with no requests -> no core resp, rdata registers unchanged.
REQ-035 Core changes imem_addr 0x100->0x200 mid-BUSY_I -> mem_addr stays 0x100 until completion.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Package   : rv32i_types
//  Purpose   : Shared types for the instruction/data memory arbiter: the
//              arbiter state encoding and the unified memory request bundle.
//  Revision  : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Arbiter FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // One request as presented on the unified memory port
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    // Cleared request: no address, no masks, no data
    localparam mem_req_t MEM_REQ_NONE = '0;

    // A side has a request outstanding when any of its byte masks is set
    function automatic logic req_pending(input logic [3:0] rmask,
                                         input logic [3:0] wmask);
        return (|rmask) | (|wmask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : mem_arbiter
//  Purpose   : Merges the core's instruction-fetch and data ports onto one
//              unified memory port. One transaction in flight at a time;
//              data side has priority unless round-robin is enabled.
//  Config    : MEM_ARB_RR_EN - when defined, a conflict is granted to the
//              side that was not granted last (last grant resets to imem).
//  Revision  : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t  state_q;
    mem_req_t    req_q;       // latched request, drives the memory port directly
    logic [31:0] imem_rdata_q;
    logic [31:0] dmem_rdata_q;
    logic        imem_resp_q;
    logic        dmem_resp_q;

    logic        imem_pend;
    logic        dmem_pend;
    logic        grant_d;

    assign imem_pend = req_pending(imem_rmask, 4'h0);
    assign dmem_pend = req_pending(dmem_rmask, dmem_wmask);

`ifdef MEM_ARB_RR_EN
    // High when the most recent grant went to the data side
    logic last_grant_d_q;

    // Record which side won each arbitration for round-robin fairness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (grant_d) begin
                last_grant_d_q <= 1'b1;
            end else if (imem_pend) begin
                last_grant_d_q <= 1'b0;
            end
        end
    end

    // Conflict goes to whichever side lost last time
    assign grant_d = dmem_pend && (!imem_pend || !last_grant_d_q);
`else
    // Fixed priority: data side always wins
    assign grant_d = dmem_pend;
`endif

    // Arbiter FSM with registered memory-port and core-response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= MEM_REQ_NONE;
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        req_q   <= '{addr: dmem_addr, rmask: dmem_rmask,
                                     wmask: dmem_wmask, wdata: dmem_wdata};
                        state_q <= BUSY_D;
                    end else if (imem_pend) begin
                        req_q   <= '{addr: imem_addr, rmask: imem_rmask,
                                     wmask: 4'h0, wdata: 32'h0};
                        state_q <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_resp) begin
                        imem_rdata_q <= mem_rdata;
                        imem_resp_q  <= 1'b1;
                        req_q.rmask  <= 4'h0;
                        req_q.wmask  <= 4'h0;
                        state_q      <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_resp) begin
                        dmem_rdata_q <= mem_rdata;
                        dmem_resp_q  <= 1'b1;
                        req_q.rmask  <= 4'h0;
                        req_q.wmask  <= 4'h0;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    // Response pulse lasts exactly this one cycle
                    imem_resp_q <= 1'b0;
                    dmem_resp_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = req_q.addr;
    assign mem_rmask  = req_q.rmask;
    assign mem_wmask  = req_q.wmask;
    assign mem_wdata  = req_q.wdata;
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;
    assign imem_resp  = imem_resp_q;
    assign dmem_resp  = dmem_resp_q;

endmodule
`default_nettype wire
